// File: rtl/set_asso_cache_4w_256s.sv
// 4-way set-associative write-back/write-allocate cache, 256 sets of one word.
// A four-state FSM sequences lookup, dirty-victim write-back and line fill.
module set_asso_cache_4w_256s (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cpu_op,
  input  logic        cpu_valid,
  input  logic [31:0] cache_addr,
  input  logic [31:0] cpu_write_data,
  output logic        cache_ready,
  output logic [31:0] cache_data,
  output logic        cache_op,
  output logic        cache_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] cache_write_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);
  localparam int WAYS  = 4;
  localparam int SETS  = 256;
  localparam int TAG_W = 22;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        victim_q, victim_d;
  logic              cache_ready_q, cache_ready_d;
  logic [31:0]       cache_data_q, cache_data_d;

  logic [WAYS-1:0]            valid_q [SETS];
  logic [WAYS-1:0]            dirty_q [SETS];
  logic [WAYS-1:0][1:0]       lru_q   [SETS];
  logic [WAYS-1:0][TAG_W-1:0] tag_ram [SETS];
  logic [WAYS-1:0][31:0]      data_ram[SETS];

  logic [7:0]       idx;
  logic [TAG_W-1:0] tag;
  logic             unused_byte_sel;

  assign idx             = cache_addr[9:2];
  assign tag             = cache_addr[31:10];
  assign unused_byte_sel = ^cache_addr[1:0];

  logic            hit;
  logic [1:0]      hit_way, miss_way;
  logic [WAYS-1:0][1:0] lru_upd;
  logic            hit_we, fill_we, wb_done;

  // Lookup, victim choice and the post-hit age vector for the addressed set.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    miss_way = '0;
    lru_upd  = lru_q[idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_ram[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
      if (lru_q[idx][w] == 2'd3) miss_way = 2'(w);
    end
    // Descending scan so the lowest invalid way wins over the oldest way.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) miss_way = 2'(w);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (2'(w) == hit_way)                       lru_upd[w] = 2'd0;
      else if (lru_q[idx][w] < lru_q[idx][hit_way]) lru_upd[w] = lru_q[idx][w] + 2'd1;
      else                                         lru_upd[w] = lru_q[idx][w];
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q       <= IDLE;
      victim_q      <= '0;
      cache_ready_q <= 1'b0;
      cache_data_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        lru_q[s]   <= {2'd3, 2'd2, 2'd1, 2'd0};
      end
    end else begin
      state_q       <= state_d;
      victim_q      <= victim_d;
      cache_ready_q <= cache_ready_d;
      cache_data_q  <= cache_data_d;
      if (hit_we) begin
        lru_q[idx] <= lru_upd;
        if (!cpu_op) dirty_q[idx][hit_way] <= 1'b1;
      end
      if (wb_done) dirty_q[idx][victim_q] <= 1'b0;
      if (fill_we) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      if (hit_we && !cpu_op) data_ram[idx][hit_way] <= cpu_write_data;
      if (fill_we) begin
        data_ram[idx][victim_q] <= mem_data;
        tag_ram[idx][victim_q]  <= tag;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    cache_ready_d = 1'b0;
    cache_data_d  = cache_data_q;
    hit_we        = 1'b0;
    fill_we       = 1'b0;
    wb_done       = 1'b0;
    unique case (state_q)
      IDLE: if (cpu_valid && !cache_ready_q) state_d = COMPARE;
      COMPARE: begin
        if (hit) begin
          hit_we        = 1'b1;
          cache_ready_d = 1'b1;
          state_d       = IDLE;
          if (cpu_op) cache_data_d = data_ram[idx][hit_way];
        end else begin
          victim_d = miss_way;
          state_d  = (valid_q[idx][miss_way] && dirty_q[idx][miss_way]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: if (mem_ready) begin
        wb_done = 1'b1;
        state_d = ALLOCATE;
      end
      ALLOCATE: if (mem_ready) begin
        fill_we = 1'b1;
        state_d = COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cache_valid      = 1'b0;
    cache_op         = 1'b0;
    mem_addr         = '0;
    cache_write_data = '0;
    unique case (state_q)
      WRITEBACK: begin
        cache_valid      = 1'b1;
        cache_op         = 1'b0;
        mem_addr         = {tag_ram[idx][victim_q], idx, 2'b00};
        cache_write_data = data_ram[idx][victim_q];
      end
      ALLOCATE: begin
        cache_valid = 1'b1;
        cache_op    = 1'b1;
        mem_addr    = {cache_addr[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  assign cache_ready = cache_ready_q;
  assign cache_data  = cache_data_q;
endmodule

// File: tb/tb_set_asso_cache_4w_256s.sv
// Directed bench for the 4-way cache: misses, hits, write-back eviction,
// write-allocate and reset during a fill, with expectations worked by hand.
module tb_set_asso_cache_4w_256s;
  logic        clk = 1'b0;
  logic        nrst, cpu_op, cpu_valid, mem_ready;
  logic [31:0] cache_addr, cpu_write_data, mem_data;
  logic        cache_ready, cache_op, cache_valid;
  logic [31:0] cache_data, mem_addr, cache_write_data;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  set_asso_cache_4w_256s dut (
    .clk(clk), .nrst(nrst), .cpu_op(cpu_op), .cpu_valid(cpu_valid),
    .cache_addr(cache_addr), .cpu_write_data(cpu_write_data),
    .cache_ready(cache_ready), .cache_data(cache_data), .cache_op(cache_op),
    .cache_valid(cache_valid), .mem_addr(mem_addr), .cache_write_data(cache_write_data),
    .mem_ready(mem_ready), .mem_data(mem_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_start(input logic op, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    cpu_op = op; cache_addr = addr; cpu_write_data = wd; cpu_valid = 1'b1;
  endtask

  // Waits for a memory request, checks it, holds for 'delay' cycles, then answers.
  task automatic mem_serve(input string tag, input logic op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int delay);
    int n = 0;
    while (cache_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, " req"}, 32'(cache_valid), 32'd1);
    chk({tag, " op"}, 32'(cache_op), 32'(op));
    chk({tag, " addr"}, mem_addr, addr);
    if (!op) chk({tag, " wdata"}, cache_write_data, wd);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk({tag, " hold"}, {31'd0, cache_valid}, 32'd1);
      chk({tag, " hold addr"}, mem_addr, addr);
    end
    mem_data = rd; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; mem_data = '0;
  endtask

  task automatic cpu_finish(input string tag, input logic [31:0] exp);
    int n = 0;
    while (cache_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, " ready"}, 32'(cache_ready), 32'd1);
    chk({tag, " data"}, cache_data, exp);
    cpu_valid = 1'b0;
    @(negedge clk);
    chk({tag, " pulse"}, 32'(cache_ready), 32'd0);
  endtask

  task automatic rd_miss(input string tag, input logic [31:0] addr, input logic [31:0] rd);
    cpu_start(1'b1, addr, '0);
    mem_serve(tag, 1'b1, addr, '0, rd, 0);
    cpu_finish(tag, rd);
  endtask

  // Hit: ready exactly two edges after cpu_valid is sampled, never any memory request.
  task automatic hit_access(input string tag, input logic op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp);
    cpu_start(op, addr, wd);
    @(negedge clk);
    chk({tag, " early"}, {30'd0, cache_ready, cache_valid}, 32'd0);
    @(negedge clk);
    chk({tag, " ready"}, {30'd0, cache_ready, cache_valid}, 32'd2);
    chk({tag, " data"}, cache_data, exp);
    cpu_valid = 1'b0;
    @(negedge clk);
    chk({tag, " pulse"}, {30'd0, cache_ready, cache_valid}, 32'd0);
  endtask

  initial begin
    int n;
    nrst = 1'b1; cpu_op = 1'b0; cpu_valid = 1'b0; mem_ready = 1'b0;
    cache_addr = '0; cpu_write_data = '0; mem_data = '0;
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(cache_ready), 32'd0);
    chk("rst valid", 32'(cache_valid), 32'd0);
    chk("rst op", 32'(cache_op), 32'd0);
    chk("rst data", cache_data, 32'd0);
    chk("rst addr", mem_addr, 32'd0);
    chk("rst wdata", cache_write_data, 32'd0);
    nrst = 1'b0;

    // Cold read with a slow memory: request must be held until mem_ready.
    cpu_start(1'b1, 32'h0, '0);
    mem_serve("cold0", 1'b1, 32'h0, '0, 32'h11111111, 3);
    cpu_finish("cold0", 32'h11111111);

    rd_miss("rd4", 32'h4, 32'h22222222);
    rd_miss("rd8", 32'h8, 32'h33333333);
    rd_miss("rdC", 32'hC, 32'h44444444);
    hit_access("rehit0", 1'b1, 32'h0, '0, 32'h11111111);

    // Write hit leaves cache_data holding the last read result.
    hit_access("wr4", 1'b0, 32'h4, 32'hAAAA5555, 32'h11111111);
    hit_access("rehit4", 1'b1, 32'h4, '0, 32'hAAAA5555);

    // Fill set 0; way 0 ends up oldest and dirty, so 0x1000 evicts it.
    hit_access("wr0", 1'b0, 32'h0, 32'hDEADBEEF, 32'hAAAA5555);
    rd_miss("rd400", 32'h400, 32'h66666666);
    rd_miss("rd800", 32'h800, 32'h77777777);
    rd_miss("rdC00", 32'hC00, 32'h88888888);
    cpu_start(1'b1, 32'h1000, '0);
    mem_serve("wb0", 1'b0, 32'h0, 32'hDEADBEEF, '0, 1);
    mem_serve("fill1000", 1'b1, 32'h1000, '0, 32'h99999999, 0);
    cpu_finish("rd1000", 32'h99999999);
    hit_access("hit400", 1'b1, 32'h400, '0, 32'h66666666);

    // Write miss allocates then writes; the dirty line is written back on eviction.
    cpu_start(1'b0, 32'h10, 32'h12345678);
    mem_serve("wmiss10", 1'b1, 32'h10, '0, 32'hCAFEF00D, 0);
    cpu_finish("wmiss10", 32'h66666666);
    hit_access("hit10", 1'b1, 32'h10, '0, 32'h12345678);
    rd_miss("rd410", 32'h410, 32'h01010101);
    rd_miss("rd810", 32'h810, 32'h02020202);
    rd_miss("rdC10", 32'hC10, 32'h03030303);
    cpu_start(1'b1, 32'h1010, '0);
    mem_serve("wb10", 1'b0, 32'h10, 32'h12345678, '0, 0);
    mem_serve("fill1010", 1'b1, 32'h1010, '0, 32'h04040404, 2);
    cpu_finish("rd1010", 32'h04040404);

    // Reset while a fill is outstanding.
    cpu_start(1'b1, 32'h20, '0);
    n = 0;
    while (cache_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("alloc20 req", 32'(cache_valid), 32'd1);
    nrst = 1'b1; cpu_valid = 1'b0;
    @(negedge clk);
    chk("midrst valid", 32'(cache_valid), 32'd0);
    chk("midrst ready", 32'(cache_ready), 32'd0);
    nrst = 1'b0;
    @(negedge clk);
    chk("postrst ready", {30'd0, cache_ready, cache_valid}, 32'd0);
    rd_miss("postrst0", 32'h0, 32'h13131313);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
